mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- E-stage multiply/divide unit (MDU) of the 5-stage MIPS pipeline.
- Consumes the E-stage copies of the decoder's `ISMULTDIV` and `MULTSel` outputs, plus forwarded rs/rt operands.
- Owns the HI/LO registers and models the multi-cycle latency of mult/multu/div/divu.
- `Busy` and `Start` feed the hazard unit, which stalls any D-stage MD-class instruction.

Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (1..15).
- DIV_CYCLES, 10, Busy duration for div/divu (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets).
- Start  in  1  E-stage `ISMULTDIV`; the instruction in E is MD-class.
- MULTSel  in  3  {funct[3], funct[1:0]} of the E instruction.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- Busy  out  1  long operation in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.
- Out  out  32  mfhi/mflo read data, muxed into the E result.

Behaviour:
- MULTSel encoding:
  - 000 mfhi, 001 mthi, 010 mflo, 011 mtlo.
  - 100 mult, 101 multu, 110 div, 111 divu.
- Reset (reset==0 at edge): HI=0, LO=0, Busy=0, counter=0, shadow result=0. Reset mid-operation aborts the operation; no HI/LO write follows.
- States: IDLE (Busy=0) and RUN (Busy=1). A 4-bit down-counter `cnt` encodes the state (cnt!=0 means RUN).
- IDLE, Start & MULTSel[2] at edge t:
  - compute the 64-bit result from A/B at that edge; store it in shadow hi_r/lo_r;
  - load cnt with MULT_CYCLES or DIV_CYCLES.
- RUN: cnt decrements each edge.
  - Busy=1 for exactly N cycles, t+1..t+N.
  - At the edge ending cycle t+N, HI<=hi_r and LO<=lo_r, and Busy falls.
  - New values are visible in cycle t+N+1.
- Arithmetic:
  - mult: signed 32x32->64, {HI,LO}=product.
  - multu: unsigned product.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - 0x80000000 div -1: LO=0x80000000, HI=0.
  - divu: unsigned.
- Divide by zero (B==0, div/divu): the operation runs with full Busy timing; HI/LO are left unchanged at completion.
- mthi/mtlo with Start in IDLE: HI<=A or LO<=A at the next edge; Busy stays 0.
- mfhi/mflo: Out=HI or LO combinationally, current register value. For any other MULTSel, Out=0.
- Start while Busy=1 is ignored: no state change, Out still valid. The hazard unit guarantees this never occurs; Start must not be trusted in that case.
- Busy is registered. It is 0 in cycle t, so the hazard unit stalls on (Start & MULTSel[2]) | Busy.

Optional Feature:
- Macro MDU_REQ_CANCEL_EN adds input port `Req` (1 bit, exception/interrupt request from the CP0 stage).
- With the macro: Start is gated by ~Req. A Start cycle with Req=1 launches nothing and writes nothing (mthi/mtlo suppressed). An in-flight RUN is not cancelled and completes normally.
- Without the macro: no Req port; Start is always honoured.

Decomposition:
- Shared include/package holds:
  - MULTSel code constants: MD_MFHI, MD_MTHI, MD_MFLO, MD_MTLO, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - default cycle counts.
- No sub-module is natural. A single flat module holds the counter, shadow registers, HI/LO and the read mux.

Test Plan:
- Reset then mthi A=0x12345678; next cycle mflo/mfhi → HI=0x12345678, LO=0, Busy never 1.
- mult A=0xFFFFFFFE (-2), B=3 → Busy high cycles t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA. HI/LO unchanged before t+6.
- multu, same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 Busy cycles.
- div A=0xFFFFFFF9 (-7), B=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu, same operands → LO=0x7FFFFFFC, HI=1.
- divu with B=0 after HI=0xA, LO=0xB → Busy for 10 cycles, then HI=0xA, LO=0xB unchanged.
- div launched, then reset=0 at Busy cycle 4 → Busy=0, HI=LO=0 next cycle, no later writeback. With MDU_REQ_CANCEL_EN: mult with Req=1 → Busy stays 0 and HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - MULTSel codes, default latencies and divide helper for the MDU
package mult_div_unit_pkg;

    // MULTSel = {funct[3], funct[1:0]} of the E-stage instruction
    localparam logic [2:0] MD_MFHI  = 3'b000;
    localparam logic [2:0] MD_MTHI  = 3'b001;
    localparam logic [2:0] MD_MFLO  = 3'b010;
    localparam logic [2:0] MD_MTLO  = 3'b011;
    localparam logic [2:0] MD_MULT  = 3'b100;
    localparam logic [2:0] MD_MULTU = 3'b101;
    localparam logic [2:0] MD_DIV   = 3'b110;
    localparam logic [2:0] MD_DIVU  = 3'b111;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Returns {remainder, quotient}. Signed divide works on magnitudes so that
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    // A zero divisor is replaced by 1 only to keep the result defined; the
    // caller discards it.
    function automatic logic [63:0] md_divide(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ma    = neg_a ? -a : a;
        mb    = neg_b ? -b : b;
        if (mb == 32'd0) begin
            mb = 32'd1;
        end
        q = ma / mb;
        r = ma % mb;
        if (neg_a ^ neg_b) begin
            q = -q;
        end
        if (neg_a) begin
            r = -r;
        end
        return {r, q};
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage multiply/divide unit owning HI/LO with modelled latency
//
// Optional feature: define MDU_REQ_CANCEL_EN to add the Req input, which
// suppresses any Start seen in the same cycle (in-flight operations finish).
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   Req      (MDU_REQ_CANCEL_EN only) CP0 exception/interrupt request
//   Start    E-stage instruction is MD-class
//   MULTSel  {funct[3], funct[1:0]} of the E instruction
//   A, B     forwarded rs / rt operands
//   Busy     long operation in flight (registered)
//   HI, LO   architectural HI/LO registers
//   Out      mfhi/mflo read data, 0 for other MULTSel codes
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_REQ_CANCEL_EN
    input  logic        Req,
`endif
    input  logic        Start,
    input  logic [2:0]  MULTSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        wr_q;      // clear for divide-by-zero: completion leaves HI/LO alone
    logic [31:0] hi_r_q;
    logic [31:0] lo_r_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        start_ok;
    logic        div_zero;
    logic [63:0] res_d;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;

`ifdef MDU_REQ_CANCEL_EN
    assign start_ok = Start & ~Req;
`else
    assign start_ok = Start;
`endif

    assign prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u   = {32'd0, A} * {32'd0, B};
    assign div_zero = MULTSel[1] & (B == 32'd0);

    always_comb begin
        res_d = 64'd0;
        case (MULTSel)
            MD_MULT:  res_d = prod_s;
            MD_MULTU: res_d = prod_u;
            MD_DIV:   res_d = md_divide(A, B, 1'b1);
            MD_DIVU:  res_d = md_divide(A, B, 1'b0);
            default:  res_d = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
            wr_q   <= 1'b0;
            hi_r_q <= 32'd0;
            lo_r_q <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else if (busy_q) begin
            // Start is deliberately ignored while running
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_q <= 1'b0;
                if (wr_q) begin
                    hi_q <= hi_r_q;
                    lo_q <= lo_r_q;
                end
            end
        end else if (start_ok) begin
            if (MULTSel[2]) begin
                hi_r_q <= res_d[63:32];
                lo_r_q <= res_d[31:0];
                wr_q   <= ~div_zero;
                cnt_q  <= MULTSel[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                busy_q <= 1'b1;
            end else if (MULTSel == MD_MTHI) begin
                hi_q <= A;
            end else if (MULTSel == MD_MTLO) begin
                lo_q <= A;
            end
        end
    end

    always_comb begin
        Out = 32'd0;
        case (MULTSel)
            MD_MFHI: Out = hi_q;
            MD_MFLO: Out = lo_q;
            default: Out = 32'd0;
        endcase
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int NMUL = 5;
    localparam int NDIV = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
`ifdef MDU_REQ_CANCEL_EN
    logic        Req = 1'b0;
`endif
    logic        Start = 1'b0;
    logic [2:0]  MULTSel = MD_MFHI;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    int    n_checks = 0;
    int    n_errors = 0;
    hilo_t sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef MDU_REQ_CANCEL_EN
        .Req     (Req),
`endif
        .Start   (Start),
        .MULTSel (MULTSel),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO),
        .Out     (Out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic hilo_t model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        hilo_t  r;
        longint sa;
        longint sb;
        longint q;
        longint m;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '{hi: m_hi, lo: m_lo};
        case (sel)
            MD_MULT: begin
                p = 64'(sa * sb);
                r = '{hi: p[63:32], lo: p[31:0]};
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                r = '{hi: p[63:32], lo: p[31:0]};
            end
            MD_DIV: if (b != 32'd0) begin
                q = sa / sb;
                m = sa % sb;
                r = '{hi: m[31:0], lo: q[31:0]};
            end
            MD_DIVU: if (b != 32'd0) begin
                r = '{hi: a % b, lo: a / b};
            end
            default: r = '{hi: m_hi, lo: m_lo};
        endcase
        return r;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, {32'd0, HI}, {32'd0, m_hi});
        check({tag, "_lo"}, {32'd0, LO}, {32'd0, m_lo});
    endtask

    task automatic move_to(input logic [2:0] sel, input logic [31:0] a);
        Start = 1'b1; MULTSel = sel; A = a;
        step();
        Start = 1'b0; MULTSel = MD_MFHI;
        if (sel == MD_MTHI) m_hi = a;
        if (sel == MD_MTLO) m_lo = a;
        check("mt_busy", {63'd0, Busy}, 64'd0);
    endtask

    // Launch a long op; optionally try an mthi in busy cycle 2, which must be ignored.
    task automatic run_long(input string tag, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b,
                            input int n, input bit inject);
        hilo_t exp;
        hilo_t got;
        sb_q.push_back(model(sel, a, b));
        Start = 1'b1; MULTSel = sel; A = a; B = b;
        step();
        Start = 1'b0; MULTSel = MD_MFHI;
        for (int i = 1; i <= n; i++) begin
            check({tag, "_busy"}, {63'd0, Busy}, 64'd1);
            check({tag, "_hold"}, {HI, LO}, {m_hi, m_lo});
            if (inject && i == 2) begin
                Start = 1'b1; MULTSel = MD_MTHI; A = 32'hDEAD_BEEF;
            end
            step();
            Start = 1'b0; MULTSel = MD_MFHI;
        end
        check({tag, "_done"}, {63'd0, Busy}, 64'd0);
        exp = sb_q.pop_front();
        got = '{hi: HI, lo: LO};
        check({tag, "_res"}, got, exp);
        m_hi = exp.hi;
        m_lo = exp.lo;
        MULTSel = MD_MFHI; #1;
        check({tag, "_mfhi"}, {32'd0, Out}, {32'd0, m_hi});
        MULTSel = MD_MFLO; #1;
        check({tag, "_mflo"}, {32'd0, Out}, {32'd0, m_lo});
        MULTSel = MD_MFHI;
    endtask

    initial begin
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check_regs("rst");

        move_to(MD_MTHI, 32'h1234_5678);
        MULTSel = MD_MFHI; #1;
        check("mthi_mfhi", {32'd0, Out}, 64'h1234_5678);
        MULTSel = MD_MFLO; #1;
        check("mthi_mflo", {32'd0, Out}, 64'd0);
        MULTSel = MD_MTHI; #1;
        check("out_other", {32'd0, Out}, 64'd0);

        run_long("mult",  MD_MULT,  32'hFFFF_FFFE, 32'd3, NMUL, 1'b0);
        check("mult_k", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_long("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, NMUL, 1'b0);
        check("multu_k", {HI, LO}, 64'h0000_0002_FFFF_FFFA);
        run_long("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, NDIV, 1'b0);
        check("div_k", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_long("divu",  MD_DIVU,  32'hFFFF_FFF9, 32'd2, NDIV, 1'b0);
        check("divu_k", {HI, LO}, 64'h0000_0001_7FFF_FFFC);
        run_long("divovf", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, NDIV, 1'b0);
        check("divovf_k", {HI, LO}, 64'h0000_0000_8000_0000);
        run_long("ign", MD_MULT, 32'd7, 32'hFFFF_FFF7, NMUL, 1'b1);

        move_to(MD_MTHI, 32'hA);
        move_to(MD_MTLO, 32'hB);
        run_long("div0", MD_DIVU, 32'd100, 32'd0, NDIV, 1'b0);
        check("div0_k", {HI, LO}, 64'h0000_000A_0000_000B);

        for (int k = 0; k < 4; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [2:0]  rs;
            ra = $urandom;
            rb = $urandom;
            rs = 3'(3'b100 | 3'($urandom_range(0, 3)));
            run_long("rnd", rs, ra, rb, rs[1] ? NDIV : NMUL, 1'b0);
        end

        // reset in busy cycle 4 of a div aborts it
        Start = 1'b1; MULTSel = MD_DIV; A = 32'd50; B = 32'd7;
        step();
        Start = 1'b0; MULTSel = MD_MFHI;
        step(); step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check_regs("abort");
        for (int i = 0; i < NDIV + 2; i++) begin
            step();
            check("abort_idle", {63'd0, Busy}, 64'd0);
        end
        check_regs("abort_late");

`ifdef MDU_REQ_CANCEL_EN
        move_to(MD_MTLO, 32'h55);
        Req = 1'b1; Start = 1'b1; MULTSel = MD_MULT; A = 32'd9; B = 32'd9;
        step();
        MULTSel = MD_MTHI; A = 32'h77;
        step();
        Req = 1'b0; Start = 1'b0; MULTSel = MD_MFHI;
        for (int i = 0; i < NMUL + 1; i++) begin
            check("req_busy", {63'd0, Busy}, 64'd0);
            step();
        end
        check_regs("req");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
